// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: turns the byte-wide ioctl download stream into
// toggle-handshake writes on two SDRAM ports. Port 1 receives every byte.
// Port 2 also receives the bytes whose address falls in [P2_START, P2_END).
// rom_loaded and core_reset are released only once every accepted byte
// has been acknowledged.
module rom_dl_sequencer #(
  parameter int unsigned ROM_INDEX = 0,
  parameter int unsigned FIFO_AW   = 2,
  parameter logic [24:0] P2_START  = 25'h0C000,
  parameter logic [24:0] P2_END    = 25'h40000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              port1_req,
  input  logic              port1_ack,
  output logic [22:0]       port1_a,
  output logic [1:0]        port1_ds,
  output logic [15:0]       port1_d,
  output logic              port1_we,
  output logic              port2_req,
  input  logic              port2_ack,
  output logic [22:0]       port2_a,
  output logic [1:0]        port2_ds,
  output logic [15:0]       port2_d,
  output logic              port2_we,
  output logic              rom_loaded,
  output logic              core_reset,
  output logic              overflow,
  output logic [FIFO_AW:0]  fifo_level
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_ISSUE, S_WAIT} state_t;

  function automatic logic in_p2_window(input logic [24:0] a);
    return (a >= P2_START) && (a < P2_END);
  endfunction

  logic              dl_match;
  logic              wr_p0;
  logic              cap_vld_p0;
  logic [23:0]       cap_addr_p0;
  logic [7:0]        cap_dout_p0;
  logic              cap_p2_p0;

  logic [23:0]       fifo_addr [DEPTH];
  logic [7:0]        fifo_dout [DEPTH];
  logic              fifo_p2   [DEPTH];
  logic [FIFO_AW:0]  wr_ptr;
  logic [FIFO_AW:0]  rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic [23:0]       head_addr;
  logic [7:0]        head_dout;
  logic              head_p2;

  state_t            state;
  state_t            state_nxt;
  logic              pop;
  logic              issue;
  logic              done;
  logic              cur_p2;

  logic              dl_p0;
  logic              dl_seen;
  logic              busy;

  assign dl_match   = ioctl_download & (ioctl_index == ROM_INDEX[7:0]);
  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign push       = cap_vld_p0 & ~fifo_full;
  assign head_addr  = fifo_addr[rd_ptr[FIFO_AW-1:0]];
  assign head_dout  = fifo_dout[rd_ptr[FIFO_AW-1:0]];
  assign head_p2    = fifo_p2[rd_ptr[FIFO_AW-1:0]];
  assign busy       = ~fifo_empty | (state != S_IDLE) | cap_vld_p0;

  // Stage p0: detect the ioctl_wr rising edge, one capture per pulse
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_p0      <= 1'b0;
      cap_vld_p0 <= 1'b0;
    end else begin
      wr_p0      <= ioctl_wr;
      cap_vld_p0 <= ioctl_wr & ~wr_p0 & dl_match;
    end
  end

  // Stage p0 data: latch the byte together with its port-2 window flag
  always_ff @(posedge clk_sys) begin
    if (ioctl_wr & ~wr_p0) begin
      cap_addr_p0 <= ioctl_addr[23:0];
      cap_dout_p0 <= ioctl_dout;
      cap_p2_p0   <= in_p2_window(ioctl_addr);
    end
  end

  // Stage p1: FIFO storage, written only when a slot is free
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr[FIFO_AW-1:0]] <= cap_addr_p0;
      fifo_dout[wr_ptr[FIFO_AW-1:0]] <= cap_dout_p0;
      fifo_p2[wr_ptr[FIFO_AW-1:0]]   <= cap_p2_p0;
    end
  end

  // FIFO pointers and the sticky dropped-byte flag
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)                    wr_ptr   <= wr_ptr + 1'b1;
      if (pop)                     rd_ptr   <= rd_ptr + 1'b1;
      if (cap_vld_p0 && fifo_full) overflow <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_SYNC;
    else       state <= state_nxt;
  end

  // FSM next state: one byte in flight, both acks required for window bytes
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      S_SYNC:  state_nxt = S_IDLE;
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if ((port1_ack == port1_req) && (!cur_p2 || (port2_ack == port2_req))) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_SYNC;
    endcase
  end

  // Stage p2: SDRAM port registers, request toggles and write enables
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
      port1_we  <= 1'b0;
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
      port2_we  <= 1'b0;
      cur_p2    <= 1'b0;
    end else begin
      if (state == S_SYNC) begin
        port1_req <= port1_ack;
        port2_req <= port2_ack;
      end
      if (pop) begin
        port1_a  <= head_addr[23:1];
        port1_ds <= {head_addr[0], ~head_addr[0]};
        port1_d  <= {head_dout, head_dout};
        port2_a  <= head_addr[23:1];
        port2_ds <= {head_addr[0], ~head_addr[0]};
        port2_d  <= {head_dout, head_dout};
        cur_p2   <= head_p2;
      end
      if (issue) begin
        port1_req <= ~port1_req;
        port1_we  <= 1'b1;
        if (cur_p2) begin
          port2_req <= ~port2_req;
          port2_we  <= 1'b1;
        end
      end
      if (done) begin
        port1_we <= 1'b0;
        port2_we <= 1'b0;
      end
    end
  end

  // Completion: rom_loaded follows the end of a matched download once idle
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_p0      <= 1'b0;
      dl_seen    <= 1'b0;
      rom_loaded <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      dl_p0      <= dl_match;
      core_reset <= ~rom_loaded | dl_match | busy;
      if (dl_match && !dl_p0) begin
        dl_seen    <= 1'b1;
        rom_loaded <= 1'b0;
      end else if (dl_seen && !dl_match && !busy) begin
        rom_loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer with a bench-side SDRAM ack responder.
module tb_rom_dl_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_ack, port1_we;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req, port2_ack, port2_we;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        rom_loaded, core_reset, overflow;
  logic [2:0]  fifo_level;

  rom_dl_sequencer dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d), .port1_we(port1_we),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d), .port2_we(port2_we),
    .rom_loaded(rom_loaded), .core_reset(core_reset),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // responder controls (written by the main sequence only)
  logic stall1 = 1'b0, stall2 = 1'b0;
  int   dly1 = 1, dly2 = 1;
  int   force1_req = 0;

  // monitor results
  int          tog1 = 0, tog2 = 0;
  int          iss_cyc1 = 0, iss_cyc2 = 0, ack2_cyc = 0;
  logic        prev1 = 1'b0, prev2 = 1'b0;
  logic [22:0] a1, a2;
  logic [1:0]  ds1, ds2;
  logic [15:0] d1, d2;
  logic        we1, we2;

  int b1, b2;
  logic we_any;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // request monitor: snapshot the port registers whenever a req toggles
  always @(negedge clk_sys) begin
    if (port1_req != prev1) begin
      tog1 = tog1 + 1; iss_cyc1 = cyc;
      a1 = port1_a; ds1 = port1_ds; d1 = port1_d; we1 = port1_we;
    end
    if (port2_req != prev2) begin
      tog2 = tog2 + 1; iss_cyc2 = cyc;
      a2 = port2_a; ds2 = port2_ds; d2 = port2_d; we2 = port2_we;
    end
    prev1 = port1_req;
    prev2 = port2_req;
  end

  // SDRAM ack responder: acknowledges dlyN negedges after a request
  initial begin : responder
    int cnt1, cnt2, force1_done;
    cnt1 = 0; cnt2 = 0; force1_done = 0;
    port1_ack = 1'b0;
    port2_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (force1_req != force1_done) begin
        port1_ack = port1_req;
        force1_done = force1_req;
      end else if (!stall1 && port1_req != port1_ack) begin
        cnt1 = cnt1 + 1;
        if (cnt1 >= dly1) begin port1_ack = port1_req; cnt1 = 0; end
      end else cnt1 = 0;
      if (!stall2 && port2_req != port2_ack) begin
        cnt2 = cnt2 + 1;
        if (cnt2 >= dly2) begin port2_ack = port2_req; cnt2 = 0; ack2_cyc = cyc; end
      end else cnt2 = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass = n_pass + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_pulse(input logic [24:0] addr, input logic [7:0] data, input int len);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr = 1'b1;
    tick(len);
    ioctl_wr = 1'b0;
    tick(1);
  endtask

  task automatic wait_tog1(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (tog1 < target && n < budget) begin tick(1); n++; end
    check(tag, tog1, target);
  endtask

  task automatic wait_loaded(input string tag, input int budget);
    int n;
    n = 0;
    while (!rom_loaded && n < budget) begin tick(1); n++; end
    check(tag, rom_loaded, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    tick(3);
    check("rst_req1", port1_req, 0);
    check("rst_req2", port2_req, 0);
    check("rst_we", {port1_we, port2_we}, 0);
    check("rst_loaded", rom_loaded, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);
    reset = 1'b0;
    tick(3);

    // 1: single byte, port 1 only
    dly1 = 2;
    ioctl_download = 1'b1; tick(1);
    b1 = tog1; b2 = tog2;
    wr_pulse(25'h00003, 8'hA5, 1);
    wait_tog1(b1 + 1, 20, "t1_issue");
    check("t1_a", a1, 23'h000001);
    check("t1_ds", ds1, 2'b10);
    check("t1_d", d1, 16'hA5A5);
    check("t1_we", we1, 1);
    check("t1_no_port2", tog2, b2);
    check("t1_cr_during_dl", core_reset, 1);
    tick(6);
    ioctl_download = 1'b0;
    wait_loaded("t1_loaded", 20);
    check("t1_cr_same_cycle", core_reset, 1);
    tick(1);
    check("t1_cr_released", core_reset, 0);

    // 2: port-2 window, slow port-2 ack, window boundaries
    dly1 = 1; dly2 = 11;
    ioctl_download = 1'b1; tick(1);
    check("t2_loaded_cleared", rom_loaded, 0);
    b1 = tog1; b2 = tog2;
    wr_pulse(25'h0C000, 8'h3C, 1);
    wr_pulse(25'h00010, 8'h11, 1);
    wait_tog1(b1 + 1, 20, "t2_issue1");
    check("t2_port2_toggled", tog2, b2 + 1);
    check("t2_same_cycle", iss_cyc2, iss_cyc1);
    check("t2_a2", a2, 23'h006000);
    check("t2_ds2", ds2, 2'b01);
    check("t2_d2", d2, 16'h3C3C);
    tick(6);
    check("t2_we1_held", port1_we, 1);
    check("t2_we2_held", port2_we, 1);
    check("t2_next_held", tog1, b1 + 1);
    wait_tog1(b1 + 2, 30, "t2_issue2");
    check("t2_after_ack2", iss_cyc1 > ack2_cyc, 1);
    check("t2_b_port1_only", tog2, b2 + 1);
    wr_pulse(25'h3FFFF, 8'h77, 1);
    wr_pulse(25'h40000, 8'h88, 1);
    wr_pulse(25'h0BFFF, 8'h99, 1);
    wait_tog1(b1 + 5, 80, "t2_drain");
    check("t2_port2_count", tog2, b2 + 2);
    check("t2_last_a2", a2, 23'h01FFFF);
    check("t2_last_ds2", ds2, 2'b10);
    check("t2_last_d2", d2, 16'h7777);
    tick(4);
    ioctl_download = 1'b0;
    wait_loaded("t2_loaded", 20);

    // 3: overflow with stalled acks
    dly1 = 1; stall1 = 1'b1;
    ioctl_download = 1'b1; tick(1);
    b1 = tog1;
    for (int i = 0; i < 6; i++) wr_pulse(25'h00100 + 25'(i), 8'(i), 1);
    tick(2);
    check("t3_level_full", fifo_level, 4);
    check("t3_overflow", overflow, 1);
    check("t3_one_in_flight", tog1, b1 + 1);
    stall1 = 1'b0;
    wait_tog1(b1 + 5, 60, "t3_resume");
    tick(10);
    check("t3_exact_count", tog1, b1 + 5);
    check("t3_drained", fifo_level, 0);
    ioctl_download = 1'b0;
    wait_loaded("t3_loaded", 20);
    check("t3_overflow_sticky", overflow, 1);

    // 4: long ioctl_wr pulse
    ioctl_download = 1'b1; tick(1);
    b1 = tog1;
    wr_pulse(25'h00200, 8'h5A, 5);
    tick(10);
    check("t4_one_toggle", tog1, b1 + 1);
    check("t4_a", a1, 23'h000100);
    check("t4_ds", ds1, 2'b01);
    check("t4_d", d1, 16'h5A5A);
    check("t4_level", fifo_level, 0);
    ioctl_download = 1'b0;
    wait_loaded("t4_loaded", 20);
    tick(2);

    // 5: other index ignored
    b1 = tog1; b2 = tog2;
    ioctl_index = 8'd1; ioctl_download = 1'b1; tick(1);
    for (int i = 0; i < 3; i++) wr_pulse(25'h00040 + 25'(i), 8'hF0, 1);
    tick(5);
    check("t5_no_req1", tog1, b1);
    check("t5_no_req2", tog2, b2);
    check("t5_loaded_kept", rom_loaded, 1);
    check("t5_cr_kept", core_reset, 0);
    check("t5_level", fifo_level, 0);
    ioctl_download = 1'b0; ioctl_index = 8'd0;
    tick(3);
    check("t5_loaded_after", rom_loaded, 1);

    // 6: async reset while waiting, ack already matching req
    stall1 = 1'b1; stall2 = 1'b1;
    ioctl_download = 1'b1; tick(1);
    b1 = tog1;
    wr_pulse(25'h00400, 8'hE1, 1);
    wait_tog1(b1 + 1, 20, "t6_issue");
    check("t6_req_pre", port1_req, 1);
    check("t6_we_pre", port1_we, 1);
    force1_req = force1_req + 1;
    @(negedge clk_sys); #1;
    reset = 1'b1; #1;
    check("t6_rst_req1", port1_req, 0);
    check("t6_rst_we1", port1_we, 0);
    check("t6_rst_loaded", rom_loaded, 0);
    check("t6_rst_cr", core_reset, 1);
    check("t6_rst_level", fifo_level, 0);
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    tick(1);
    check("t6_sync_req1", port1_req, 1);
    check("t6_sync_req2", port2_req, 0);
    we_any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      we_any = we_any | port1_we | port2_we;
      tick(1);
    end
    check("t6_no_write", we_any, 0);
    stall1 = 1'b0; stall2 = 1'b0;
    ioctl_download = 1'b1; tick(1);
    b1 = tog1;
    wr_pulse(25'h00300, 8'hC3, 1);
    wait_tog1(b1 + 1, 20, "t6_after_issue");
    check("t6_after_a", a1, 23'h000180);
    check("t6_after_ds", ds1, 2'b01);
    check("t6_after_d", d1, 16'hC3C3);
    tick(5);
    ioctl_download = 1'b0;
    wait_loaded("t6_loaded", 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
